// File: rtl/car_detect_pkg.sv
// Shared definitions for the loop-detector conditioner: lamp bus bit positions
// and the per-channel state encoding.
package car_detect_pkg;

  // Lamp bus layout, shared with the traffic light controller.
  localparam int LAMP_NS_R = 5;
  localparam int LAMP_NS_Y = 4;
  localparam int LAMP_NS_G = 3;
  localparam int LAMP_EW_R = 2;
  localparam int LAMP_EW_Y = 1;
  localparam int LAMP_EW_G = 0;

  // Channel state is literally {deb, lat}.
  typedef enum logic [1:0] {
    ST_IDLE        = 2'b00,
    ST_LATCHED     = 2'b01,
    ST_PRESENT     = 2'b10,
    ST_PRESENT_LAT = 2'b11
  } chan_state_e;

  function automatic logic chan_deb(input chan_state_e st);
    return st[1];
  endfunction

  function automatic logic chan_lat(input chan_state_e st);
    return st[0];
  endfunction

  function automatic chan_state_e chan_pack(input logic deb, input logic lat);
    chan_state_e st;
    case ({deb, lat})
      2'b00:   st = ST_IDLE;
      2'b01:   st = ST_LATCHED;
      2'b10:   st = ST_PRESENT;
      2'b11:   st = ST_PRESENT_LAT;
      default: st = ST_IDLE;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/car_chan.sv
// One detector channel: 2-flop synchronizer, debounce filter, request latch
// cleared by own green, and the registered request output.
module car_chan
  import car_detect_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int CW         = 8
) (
  input  logic clk,
  input  logic clr,
  input  logic raw,
  input  logic grn,
  output logic car
);

  localparam logic [CW-1:0] CNT_MAX  = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  logic        s1_r;
  logic        s2_r;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_next_s;
  chan_state_e state_r;
  chan_state_e state_next_s;
  logic        deb_s;
  logic        lat_s;
  logic        deb_next_s;
  logic        lat_next_s;
  logic        car_r;

  assign deb_s = chan_deb(state_r);
  assign lat_s = chan_lat(state_r);

  // Synchronizer for the asynchronous loop input; s1 feeds nothing but s2.
  always_ff @(posedge clk) begin
    if (!clr) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
    end else begin
      s1_r <= raw;
      s2_r <= s1_r;
    end
  end

  // Next-state: debounce qualification, then latch set/clear (clear wins).
  always_comb begin
    cnt_next_s   = cnt_r;
    deb_next_s   = deb_s;
    lat_next_s   = lat_s;
    if (s2_r == deb_s) begin
      cnt_next_s = CNT_ZERO;
    end else if (cnt_r == CNT_MAX) begin
      deb_next_s = s2_r;
      cnt_next_s = CNT_ZERO;
    end else begin
      cnt_next_s = cnt_r + CNT_ONE;
    end
    if (grn) begin
      lat_next_s = 1'b0;
    end else if (deb_next_s && !deb_s) begin
      lat_next_s = 1'b1;
    end else begin
      lat_next_s = lat_s;
    end
    state_next_s = chan_pack(deb_next_s, lat_next_s);
  end

  // State, counter and request register; the request tracks next-state so it
  // rises on the same edge as the debounced level.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      car_r   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      car_r   <= deb_next_s | lat_next_s;
    end
  end

  assign car = car_r;

endmodule

// File: rtl/car_detect.sv
// Loop-detector conditioner: two independent channels producing the
// controller's nscar/ewcar requests, cleared by the matching green lamp.
module car_detect
  import car_detect_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int CW         = 8
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       ns_raw,
  input  logic       ew_raw,
  input  logic [5:0] lights,
  output logic       nscar,
  output logic       ewcar
);

  // Only the green lamps matter here; red/yellow are deliberately ignored.
  logic unused_lamps_s;
  assign unused_lamps_s = ^{lights[LAMP_NS_R], lights[LAMP_NS_Y],
                            lights[LAMP_EW_R], lights[LAMP_EW_Y]};

  car_chan #(.DEB_CYCLES(DEB_CYCLES), .CW(CW)) u_ns (
    .clk (clk),
    .clr (clr),
    .raw (ns_raw),
    .grn (lights[LAMP_NS_G]),
    .car (nscar)
  );

  car_chan #(.DEB_CYCLES(DEB_CYCLES), .CW(CW)) u_ew (
    .clk (clk),
    .clr (clr),
    .raw (ew_raw),
    .grn (lights[LAMP_EW_G]),
    .car (ewcar)
  );

endmodule

// File: tb/tb_car_detect.sv
// Directed bench for car_detect: expected outputs are queued as each cycle's
// stimulus is applied and compared one edge later.
module tb_car_detect;

  logic       clk;
  logic       clr;
  logic       ns_raw;
  logic       ew_raw;
  logic [5:0] lights;
  logic       nscar;
  logic       ewcar;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string tag;
    logic  chk_ns;
    logic  exp_ns;
    logic  chk_ew;
    logic  exp_ew;
  } exp_t;

  exp_t sb_q[$];

  car_detect #(.DEB_CYCLES(4), .CW(8)) dut (
    .clk    (clk),
    .clr    (clr),
    .ns_raw (ns_raw),
    .ew_raw (ew_raw),
    .lights (lights),
    .nscar  (nscar),
    .ewcar  (ewcar)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: no expectation queued");
    end else begin
      e = sb_q.pop_front();
      if (e.chk_ns) begin
        checks++;
        assert (nscar === e.exp_ns) else begin
          errors++;
          $error("FAIL %s nscar: got %b expected %b", e.tag, nscar, e.exp_ns);
        end
      end
      if (e.chk_ew) begin
        checks++;
        assert (ewcar === e.exp_ew) else begin
          errors++;
          $error("FAIL %s ewcar: got %b expected %b", e.tag, ewcar, e.exp_ew);
        end
      end
    end
  endtask

  // One clock edge with the currently driven inputs; check outputs after it.
  task automatic step(input string tag, input logic cn, input logic en,
                      input logic ce, input logic ee);
    exp_t e;
    e.tag = tag; e.chk_ns = cn; e.exp_ns = en; e.chk_ew = ce; e.exp_ew = ee;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic steps(input string tag, input int n, input logic cn,
                       input logic en, input logic ce, input logic ee);
    for (int i = 0; i < n; i++) step(tag, cn, en, ce, ee);
  endtask

  initial begin
    clr = 1'b0; ns_raw = 1'b1; ew_raw = 1'b1; lights = 6'b100_100;
    @(negedge clk);

    // reset holds outputs low with raw high, then full qualification
    steps("rst_hold", 2, 1'b1, 1'b0, 1'b1, 1'b0);
    clr = 1'b1;
    steps("rst_rel", 5, 1'b1, 1'b0, 1'b1, 1'b0);
    step("rst_rise", 1'b1, 1'b1, 1'b1, 1'b1);

    // both greens on: latches clear, requests follow deb down at edge 6
    lights = 6'b001_001; ns_raw = 1'b0; ew_raw = 1'b0;
    steps("drain", 5, 1'b1, 1'b1, 1'b1, 1'b1);
    step("drain_fall", 1'b1, 1'b0, 1'b1, 1'b0);
    lights = 6'b100_100;
    steps("idle", 3, 1'b1, 1'b0, 1'b1, 1'b0);

    // 3-cycle glitch rejected
    lights = 6'b100_001; ns_raw = 1'b1;
    steps("glitch3", 3, 1'b1, 1'b0, 1'b1, 1'b0);
    ns_raw = 1'b0;
    steps("glitch3_low", 17, 1'b1, 1'b0, 1'b1, 1'b0);

    // 5-cycle pulse accepted and latched while NS green is off
    ns_raw = 1'b1;
    steps("pulse5", 5, 1'b1, 1'b0, 1'b1, 1'b0);
    ns_raw = 1'b0;
    step("pulse5_rise", 1'b1, 1'b1, 1'b1, 1'b0);
    steps("pulse5_latch", 10, 1'b1, 1'b1, 1'b1, 1'b0);
    lights = 6'b001_100;
    step("pulse5_served", 1'b1, 1'b0, 1'b1, 1'b0);

    // EW latch holds with EW green off, clears at next edge once served
    ew_raw = 1'b1;
    steps("ew_qual", 5, 1'b1, 1'b0, 1'b1, 1'b0);
    step("ew_rise", 1'b1, 1'b0, 1'b1, 1'b1);
    ew_raw = 1'b0;
    steps("ew_latch", 100, 1'b1, 1'b0, 1'b1, 1'b1);
    lights = 6'b100_001;
    step("ew_served", 1'b1, 1'b0, 1'b1, 1'b0);

    // served while car present: request persists, then falls 6 edges after leave
    lights = 6'b100_100; ns_raw = 1'b1;
    steps("ns_qual", 5, 1'b1, 1'b0, 1'b1, 1'b0);
    step("ns_rise", 1'b1, 1'b1, 1'b1, 1'b0);
    lights = 6'b001_100;
    steps("ns_green", 5, 1'b1, 1'b1, 1'b1, 1'b0);
    ns_raw = 1'b0;
    steps("ns_drop", 5, 1'b1, 1'b1, 1'b1, 1'b0);
    step("ns_drop_fall", 1'b1, 1'b0, 1'b1, 1'b0);
    steps("ns_after", 3, 1'b1, 1'b0, 1'b1, 1'b0);

    // green on the same edge deb rises: no latch afterwards
    lights = 6'b100_100; ns_raw = 1'b1;
    steps("coll_qual", 5, 1'b1, 1'b0, 1'b1, 1'b0);
    lights = 6'b001_100;
    step("coll_rise", 1'b1, 1'b1, 1'b1, 1'b0);
    lights = 6'b100_100;
    steps("coll_hold", 2, 1'b1, 1'b1, 1'b1, 1'b0);
    ns_raw = 1'b0;
    steps("coll_drop", 5, 1'b1, 1'b1, 1'b1, 1'b0);
    step("coll_fall", 1'b1, 1'b0, 1'b1, 1'b0);
    steps("coll_nolat", 5, 1'b1, 1'b0, 1'b1, 1'b0);

    // reset mid-debounce discards the partial count
    ew_raw = 1'b1;
    steps("mid_cnt", 4, 1'b1, 1'b0, 1'b1, 1'b0);
    clr = 1'b0;
    step("mid_rst", 1'b1, 1'b0, 1'b1, 1'b0);
    clr = 1'b1;
    steps("mid_requal", 5, 1'b1, 1'b0, 1'b1, 1'b0);
    step("mid_rise", 1'b1, 1'b0, 1'b1, 1'b1);

    // reset mid-request drops the request at that edge
    clr = 1'b0;
    step("req_rst", 1'b1, 1'b0, 1'b1, 1'b0);
    clr = 1'b1; ew_raw = 1'b0;
    steps("post_rst", 8, 1'b1, 1'b0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/car_detect.md
Name: car_detect

Overview:
- Upstream conditioner for the traffic light controller; converts raw, asynchronous inductive-loop detector signals into clean nscar/ewcar requests.
- Per direction: 2-flop synchronizer, debounce filter, then a request latch that holds a request until that direction's green is shown.
- Takes the controller's lights bus as feedback to clear served requests; outputs drive the controller's nscar/ewcar inputs directly.

Parameters:
- DEB_CYCLES, 4, consecutive synchronized samples of a new level needed before the debounced level changes (legal 2..255).
- CW, 8, debounce counter width; must satisfy 2^CW > DEB_CYCLES.

Ports:
- clk  input  1  system clock, rising-edge.
- clr  input  1  reset; one clock; reset is synchronous and active-low (clr=0 sampled on a rising clk edge resets).
- ns_raw  input  1  raw North-South loop detector, asynchronous, may glitch.
- ew_raw  input  1  raw East-West loop detector, asynchronous, may glitch.
- lights  input  6  controller lamp bus {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g} = bits [5:0].
- nscar  output  1  registered NS request to controller.
- ewcar  output  1  registered EW request to controller.

Behaviour:
- Reset (clr=0 at edge): sync flops, debounced levels, counters, latches, nscar, ewcar all 0. Reset mid-debounce discards partial count; mid-request drops the request immediately (outputs 0 at that edge).
- Channels are identical and independent: NS uses ns_raw and lights[3]; EW uses ew_raw and lights[0].
- Sync: s1 <= raw; s2 <= s1. No logic on s1.
- Debounce counter:
  - If s2 == deb, cnt <= 0.
  - Else if cnt == DEB_CYCLES-1, deb <= s2 and cnt <= 0.
  - Else cnt <= cnt+1.
  - Any sample with s2 == deb restarts qualification, so pulses shorter than DEB_CYCLES samples never reach deb.
- Channel state machine (state encodes deb and lat):
  - IDLE (deb=0, lat=0).
  - PRESENT (deb=1): entered on the deb rising edge. Sets lat <= 1 unless own green is high that cycle.
  - LATCHED (deb=0, lat=1): car left before being served. Stays until own green is high.
  - Own green high at any edge clears lat. Clear beats set when both occur at the same edge.
- Output: car <= deb_next | lat_next, registered, so the request appears at the same edge deb rises.
- Latency: raw rises before edge 1 and stays stable -> car=1 at edge DEB_CYCLES+2 (edge 6 with default). Falling path has the same latency when no latch is pending.
- While own green is high, car follows deb only (a car still present extends the green; a departed car does not).
- lights bits other than [3] and [0] are ignored. Illegal lamp combinations are not checked.
- Both channels asserting the same cycle is legal; no arbitration here (arbitration belongs to the controller).

Decomposition:
- Shared header traffic_defs.vh holds localparams LAMP_NS_R=5, LAMP_NS_Y=4, LAMP_NS_G=3, LAMP_EW_R=2, LAMP_EW_Y=1, LAMP_EW_G=0. The controller uses the same header.
- One sub-module car_chan (sync + debounce + latch + output reg; ports clk, clr, raw, grn, car; parameters DEB_CYCLES, CW). It is instantiated twice in car_detect.

Test Plan:
- Reset: clr=0 for 2 edges with ns_raw=ew_raw=1 -> nscar=ewcar=0 throughout. Release clr, hold raw high -> both reach 1 at edge 6 after release.
- Glitch reject: ns_raw high for 3 clk cycles, lights=6'b100_001 -> nscar stays 0 for 20 cycles. Repeat with 5 cycles -> nscar=1 at edge 6 after the rise.
- Latch hold: ew_raw high 6 cycles then low, EW green off (lights=6'b001_100) -> ewcar stays 1 indefinitely (check 100 cycles). Set lights=6'b100_001 -> ewcar=0 at the next edge.
- Served with car present: ns_raw held high, lights switch to NS green -> nscar stays 1. Drop ns_raw -> nscar=0 exactly 6 edges later.
- Set/clear collision: deb rises on the same edge NS green is asserted -> lat remains 0. Then drop ns_raw while green is off -> nscar falls after 6 edges, no latched request.
- Mid-operation reset: ew_raw high, cnt=2, assert clr=0 for one edge, release with ew_raw still high -> ewcar=1 at edge 6 after release (full requalification).
